// File: rtl/mcl86_bus_pkg.sv
// Shared types and defaults for the minimum-mode 8088 bus responder.
package mcl86_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RD_REQ,
        ST_WR_REQ,
        ST_INTA,
        ST_DRIVE,
        ST_HOLD
    } bus_state_t;

    localparam logic STROBE_ACTIVE = 1'b0;
    localparam logic IOM_IO        = 1'b1;

    localparam logic [19:0] DEF_MEM_BASE    = 20'h00000;
    localparam logic [19:0] DEF_MEM_MASK    = 20'hF0000;
    localparam logic [15:0] DEF_IO_BASE     = 16'h0300;
    localparam logic [15:0] DEF_IO_MASK     = 16'hFFF0;
    localparam int unsigned DEF_WAIT_STATES = 2;
    localparam bit          DEF_INTA_EN     = 1'b1;

    function automatic logic [19:0] io_zext(input logic [15:0] a);
        return {4'h0, a};
    endfunction

endpackage

// File: rtl/mcl86_bus_addr_decode.sv
// Window compare on the latched bus address: I/O cycles look at A[15:0] only.
module mcl86_bus_addr_decode
    import mcl86_bus_pkg::*;
#(
    parameter logic [19:0] MEM_BASE = DEF_MEM_BASE,
    parameter logic [19:0] MEM_MASK = DEF_MEM_MASK,
    parameter logic [15:0] IO_BASE  = DEF_IO_BASE,
    parameter logic [15:0] IO_MASK  = DEF_IO_MASK
) (
    input  logic [19:0] i_addr,
    input  logic        i_iom,
    output logic        o_hit
);

    assign o_hit = (i_iom == IOM_IO) ? ((i_addr[15:0] & IO_MASK) == IO_BASE)
                                     : ((i_addr & MEM_MASK) == MEM_BASE);

endmodule

// File: rtl/mcl86_bus_responder.sv
// Far-end 8088 bus target: decodes one memory and one I/O window, turns CPU
// strobes into req/ack backing-store transactions and paces the CPU with READY.
module mcl86_bus_responder
    import mcl86_bus_pkg::*;
#(
    parameter logic [19:0] MEM_BASE    = DEF_MEM_BASE,
    parameter logic [19:0] MEM_MASK    = DEF_MEM_MASK,
    parameter logic [15:0] IO_BASE     = DEF_IO_BASE,
    parameter logic [15:0] IO_MASK     = DEF_IO_MASK,
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
    parameter bit          INTA_EN     = DEF_INTA_EN
) (
    input  logic        CORE_CLK_INT,
    input  logic        RESET_INT,
    input  logic        ALE,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic        IOM,
    input  logic        INTA_n,
    input  logic [19:0] AD_OUT,
    output logic [7:0]  AD_IN,
    output logic        AD_IN_OE,
    output logic        READY_OUT,
    output logic        SEL,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic        MEM_IO,
    output logic [19:0] MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [7:0]  MEM_RDATA,
    input  logic [7:0]  INT_VECTOR
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    bus_state_t  r_state, w_state_nxt;
    logic [19:0] r_addr;
    logic        r_iom;
    logic        r_ale_q, r_inta_q;
    logic [3:0]  r_cnt;
    logic        r_toggle, w_toggle_nxt;
    logic        r_abort, w_abort_nxt;
    logic        r_ready, w_ready_nxt;
    logic        r_sel, w_sel_nxt;
    logic        r_req, w_req_nxt;
    logic        r_we, w_we_nxt;
    logic        r_io, w_io_nxt;
    logic        r_oe, w_oe_nxt;
    logic [19:0] r_mem_addr, w_addr_nxt;
    logic [7:0]  r_adin, w_adin_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;

    logic w_hit, w_ale_fall, w_inta_fall, w_rd, w_wr, w_wait_ok;

    assign w_ale_fall  = r_ale_q & ~ALE;
    assign w_inta_fall = r_inta_q & ~INTA_n;
    assign w_rd        = (RD_n == STROBE_ACTIVE);
    assign w_wr        = (WR_n == STROBE_ACTIVE);
    assign w_wait_ok   = (r_cnt >= WS);

    mcl86_bus_addr_decode #(
        .MEM_BASE (MEM_BASE),
        .MEM_MASK (MEM_MASK),
        .IO_BASE  (IO_BASE),
        .IO_MASK  (IO_MASK)
    ) u_decode (
        .i_addr (r_addr),
        .i_iom  (r_iom),
        .o_hit  (w_hit)
    );

    // Address latch is transparent-per-cycle while ALE is high; last value before the fall wins.
    always_ff @(posedge CORE_CLK_INT) begin
        if (ALE) begin
            r_addr <= AD_OUT;
            r_iom  <= IOM;
        end
    end

    always_ff @(posedge CORE_CLK_INT) begin
        if (RESET_INT) begin
            r_state    <= ST_IDLE;
            r_ale_q    <= 1'b0;
            r_inta_q   <= 1'b1;
            r_cnt      <= 4'd0;
            r_toggle   <= 1'b0;
            r_abort    <= 1'b0;
            r_ready    <= 1'b1;
            r_sel      <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_io       <= 1'b0;
            r_oe       <= 1'b0;
            r_mem_addr <= 20'h0;
            r_adin     <= 8'h0;
            r_wdata    <= 8'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_ale_q    <= ALE;
            r_inta_q   <= INTA_n;
            if (w_ale_fall || w_inta_fall)
                r_cnt <= 4'd0;
            else if (r_cnt != 4'hF)
                r_cnt <= r_cnt + 4'd1;
            r_toggle   <= w_toggle_nxt;
            r_abort    <= w_abort_nxt;
            r_ready    <= w_ready_nxt;
            r_sel      <= w_sel_nxt;
            r_req      <= w_req_nxt;
            r_we       <= w_we_nxt;
            r_io       <= w_io_nxt;
            r_oe       <= w_oe_nxt;
            r_mem_addr <= w_addr_nxt;
            r_adin     <= w_adin_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_toggle_nxt = r_toggle;
        w_abort_nxt  = r_abort;
        w_ready_nxt  = r_ready;
        w_sel_nxt    = r_sel;
        w_req_nxt    = r_req;
        w_we_nxt     = r_we;
        w_io_nxt     = r_io;
        w_oe_nxt     = r_oe;
        w_addr_nxt   = r_mem_addr;
        w_adin_nxt   = r_adin;
        w_wdata_nxt  = r_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_ale_fall && w_hit) begin
                    w_state_nxt = ST_ARMED;
                    w_sel_nxt   = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_io_nxt    = r_iom;
                    w_addr_nxt  = (r_iom == IOM_IO) ? io_zext(r_addr[15:0]) : r_addr;
                end else if (w_inta_fall) begin
                    w_toggle_nxt = ~r_toggle;
                    if (r_toggle && INTA_EN) begin
                        w_state_nxt = ST_INTA;
                        w_sel_nxt   = 1'b1;
                        w_ready_nxt = 1'b0;
                    end
                end
            end
            ST_ARMED: begin
                if (w_rd && w_wr) begin
                    w_state_nxt = ST_HOLD;
                    w_ready_nxt = 1'b1;
                end else if (w_rd) begin
                    w_state_nxt = ST_RD_REQ;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                end else if (w_wr) begin
                    w_state_nxt = ST_WR_REQ;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = AD_OUT[7:0];
                end
            end
            ST_RD_REQ, ST_WR_REQ: begin
                // A strobe released before the ack aborts: finish the handshake, drop the data.
                if (MEM_ACK) begin
                    w_req_nxt = 1'b0;
                    w_we_nxt  = 1'b0;
                    if (r_abort || (r_state == ST_RD_REQ ? !w_rd : !w_wr)) begin
                        w_state_nxt = ST_IDLE;
                        w_sel_nxt   = 1'b0;
                        w_ready_nxt = 1'b1;
                        w_abort_nxt = 1'b0;
                    end else if (r_state == ST_RD_REQ) begin
                        w_state_nxt = ST_DRIVE;
                        w_adin_nxt  = MEM_RDATA;
                        w_oe_nxt    = 1'b1;
                        w_ready_nxt = w_wait_ok;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_ready_nxt = w_wait_ok;
                    end
                end else if (r_state == ST_RD_REQ ? !w_rd : !w_wr) begin
                    w_abort_nxt = 1'b1;
                    w_ready_nxt = 1'b1;
                end
            end
            ST_INTA: begin
                w_adin_nxt  = INT_VECTOR;
                w_oe_nxt    = 1'b1;
                w_ready_nxt = w_wait_ok;
                if (INTA_n) begin
                    w_state_nxt = ST_IDLE;
                    w_oe_nxt    = 1'b0;
                    w_sel_nxt   = 1'b0;
                    w_ready_nxt = 1'b1;
                end
            end
            ST_DRIVE: begin
                w_ready_nxt = r_ready | w_wait_ok;
                if (!w_rd) begin
                    w_state_nxt = ST_IDLE;
                    w_oe_nxt    = 1'b0;
                    w_sel_nxt   = 1'b0;
                    w_ready_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                w_ready_nxt = r_ready | w_wait_ok;
                if (!w_wr) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = 1'b0;
                    w_ready_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign AD_IN     = r_adin;
    assign AD_IN_OE  = r_oe;
    assign READY_OUT = r_ready;
    assign SEL       = r_sel;
    assign MEM_REQ   = r_req;
    assign MEM_WE    = r_we;
    assign MEM_IO    = r_io;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_wdata;

endmodule
